cp0_reg_ext: RTL and testbench

Parametrised CP0 system-control register file for the OpenMIPS core, next generation of the basic CP0 block. Holds Count/Compare/Status/Cause/EPC/BadVAddr/PRId/Config. Adds prescaled Count, exception/ERET commit from the MEM stage, and read-during-write forwarding. Produces a qualified interrupt request to the exception logic.

---
 rtl/cp0_reg_ext_if.sv | 31 +++
 rtl/cp0_reg_ext.sv | 94 +++++++++
 tb/tb_cp0_reg_ext.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cp0_reg_ext_if.sv
// cp0_reg_ext_if: MTC0/MFC0, exception/ERET commit and register-view bundle for cp0_reg_ext
interface cp0_reg_ext_if #(parameter int HW_INT_N = 6);
  logic we_i;
  logic [4:0] waddr_i;
  logic [4:0] raddr_i;
  logic [31:0] data_i;
  logic [HW_INT_N-1:0] int_i;
  logic exc_valid_i;
  logic [4:0] exc_code_i;
  logic [31:0] exc_pc_i;
  logic exc_bd_i;
  logic [31:0] exc_badvaddr_i;
  logic eret_i;
  logic [31:0] data_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] badvaddr_o;
  logic timer_int_o;
  logic int_req_o;
  modport master(
    output we_i, waddr_i, raddr_i, data_i, int_i, exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
    input data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o, timer_int_o, int_req_o
  );
  modport slave(
    input we_i, waddr_i, raddr_i, data_i, int_i, exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
    output data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o, timer_int_o, int_req_o
  );
endinterface

// File: rtl/cp0_reg_ext.sv
// cp0_reg_ext: CP0 register file with prescaled Count, timer, exception/ERET commit and MFC0 forwarding
module cp0_reg_ext #(
  parameter int HW_INT_N = 6,
  parameter int COUNT_DIV = 1,
  parameter logic [31:0] PRID_VALUE = 32'h004C0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
  input logic clk,
  input logic rst,
  cp0_reg_ext_if.slave bus
);
  localparam int PW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
  localparam logic [31:0] CAUSE_WM = 32'h00C00300;
  logic [PW-1:0] pre_q, pre_d;
  logic [31:0] count_q, count_d, compare_q, compare_d, status_q, status_d;
  logic [31:0] cause_q, cause_d, epc_q, epc_d, badvaddr_q, badvaddr_d;
  logic timer_q, timer_d;
  logic wr_count, wr_compare, wr_status, wr_cause, wr_epc, pre_wrap, fwd_hit;
  logic [5:0] ip;
  logic [31:0] cause_rd, rd;
  always_comb begin
    ip = '0;
    ip[HW_INT_N-1:0] = bus.int_i;
    wr_count = bus.we_i && bus.waddr_i == 5'd9;
    wr_compare = bus.we_i && bus.waddr_i == 5'd11;
    wr_status = bus.we_i && bus.waddr_i == 5'd12;
    wr_cause = bus.we_i && bus.waddr_i == 5'd13;
    wr_epc = bus.we_i && bus.waddr_i == 5'd14;
    pre_wrap = pre_q == PW'(COUNT_DIV - 1);
    pre_d = (wr_count || pre_wrap) ? '0 : pre_q + 1'b1;
    count_d = wr_count ? bus.data_i : count_q + {31'd0, pre_wrap};
    compare_d = wr_compare ? bus.data_i : compare_q;
    timer_d = !wr_compare && (timer_q || (compare_q != '0 && count_q == compare_q));
    status_d = wr_status ? bus.data_i : status_q;
    status_d[1] = bus.exc_valid_i || (!bus.eret_i && (wr_status ? bus.data_i[1] : status_q[1]));
    cause_d = wr_cause ? (cause_q & ~CAUSE_WM) | (bus.data_i & CAUSE_WM) : cause_q;
    cause_d[15:10] = ip;
    epc_d = wr_epc ? bus.data_i : epc_q;
    badvaddr_d = badvaddr_q;
    if (bus.exc_valid_i) begin
      if (!status_q[1]) begin
        epc_d = bus.exc_bd_i ? bus.exc_pc_i - 32'd4 : bus.exc_pc_i;
        cause_d[31] = bus.exc_bd_i;
      end
      cause_d[6:2] = bus.exc_code_i;
      badvaddr_d = (bus.exc_code_i == 5'd4 || bus.exc_code_i == 5'd5) ? bus.exc_badvaddr_i : badvaddr_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      count_q <= '0;
      compare_q <= '0;
      status_q <= 32'h10000000;
      cause_q <= '0;
      epc_q <= '0;
      badvaddr_q <= '0;
      timer_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      count_q <= count_d;
      compare_q <= compare_d;
      status_q <= status_d;
      cause_q <= cause_d;
      epc_q <= epc_d;
      badvaddr_q <= badvaddr_d;
      timer_q <= timer_d;
    end
  end
  always_comb begin
    cause_rd = cause_q | {16'd0, timer_q, 15'd0};
    case (bus.raddr_i)
      5'd8: rd = badvaddr_q;
      5'd9: rd = count_q;
      5'd11: rd = compare_q;
      5'd12: rd = status_q;
      5'd13: rd = cause_rd;
      5'd14: rd = epc_q;
      5'd15: rd = PRID_VALUE;
      5'd16: rd = CONFIG_VALUE;
      default: rd = '0;
    endcase
    fwd_hit = bus.we_i && bus.waddr_i == bus.raddr_i && bus.raddr_i inside {5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    bus.data_o = rst ? '0 : !fwd_hit ? rd : bus.raddr_i == 5'd13 ? (cause_rd & ~CAUSE_WM) | (bus.data_i & CAUSE_WM) : bus.data_i;
    bus.int_req_o = status_q[0] && !status_q[1] && |(cause_rd[15:8] & status_q[15:8]);
  end
  assign bus.count_o = count_q;
  assign bus.compare_o = compare_q;
  assign bus.status_o = status_q;
  assign bus.cause_o = cause_rd;
  assign bus.epc_o = epc_q;
  assign bus.badvaddr_o = badvaddr_q;
  assign bus.timer_int_o = timer_q;
endmodule

// File: tb/tb_cp0_reg_ext.sv
// tb_cp0_reg_ext: table-driven scoreboard bench for cp0_reg_ext with COUNT_DIV 1 and 4 instances
module tb_cp0_reg_ext;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cp0_reg_ext_if #(.HW_INT_N(6)) a();
  cp0_reg_ext_if #(.HW_INT_N(6)) b();
  cp0_reg_ext #(.HW_INT_N(6), .COUNT_DIV(1)) u1(.clk(clk), .rst(rst), .bus(a));
  cp0_reg_ext #(.HW_INT_N(6), .COUNT_DIV(4)) u4(.clk(clk), .rst(rst), .bus(b));
  typedef struct {
    string nm;
    logic pre;
    int sel;
    logic [31:0] exp;
    logic we;
    logic [4:0] wa;
    logic [4:0] ra;
    logic [31:0] d;
    logic [5:0] irq;
    logic exc;
    logic [4:0] code;
    logic [31:0] pc;
    logic bd;
    logic [31:0] bva;
    logic eret;
  } vec_t;
  typedef struct {
    string nm;
    bit u4;
    int sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];
  vec_t t1[$];
  vec_t t2[$];
  vec_t z;
  int n_cmp = 0;
  int n_bad = 0;
  int n;
  function automatic logic [31:0] obs(bit u4, int sel);
    case (sel)
      0: return u4 ? b.data_o : a.data_o;
      1: return u4 ? b.count_o : a.count_o;
      2: return u4 ? b.compare_o : a.compare_o;
      3: return u4 ? b.status_o : a.status_o;
      4: return u4 ? b.cause_o : a.cause_o;
      5: return u4 ? b.epc_o : a.epc_o;
      6: return u4 ? b.badvaddr_o : a.badvaddr_o;
      7: return {31'd0, u4 ? b.timer_int_o : a.timer_int_o};
      default: return {31'd0, u4 ? b.int_req_o : a.int_req_o};
    endcase
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic check_all();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.nm, obs(e.u4, e.sel), e.exp);
    end
  endtask
  task automatic drive(input vec_t v);
    {a.we_i, a.waddr_i, a.raddr_i, a.data_i, a.int_i, a.exc_valid_i, a.exc_code_i, a.exc_pc_i, a.exc_bd_i, a.exc_badvaddr_i, a.eret_i} = {v.we, v.wa, v.ra, v.d, v.irq, v.exc, v.code, v.pc, v.bd, v.bva, v.eret};
    {b.we_i, b.waddr_i, b.raddr_i, b.data_i, b.int_i, b.exc_valid_i, b.exc_code_i, b.exc_pc_i, b.exc_bd_i, b.exc_badvaddr_i, b.eret_i} = {v.we, v.wa, v.ra, v.d, v.irq, v.exc, v.code, v.pc, v.bd, v.bva, v.eret};
  endtask
  task automatic run(input vec_t v);
    drive(v);
    if (v.sel >= 0) sb.push_back(exp_t'{v.nm, 1'b1, v.sel, v.exp});
    @(negedge clk);
    if (v.pre) check_all();
    @(posedge clk);
    #1;
    if (!v.pre) check_all();
  endtask
  initial begin
    z = vec_t'{"idle", 1'b0, -1, 32'd0, 1'b0, 5'd0, 5'd15, 32'd0, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0};
    t1.push_back(vec_t'{"cnt_zero", 1'b0, 1, 32'd0, 1'b1, 5'd9, 5'd0, 32'd0, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t1.push_back(vec_t'{"cmp_5", 1'b0, 2, 32'd5, 1'b1, 5'd11, 5'd0, 32'd5, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    for (int i = 0; i < 7; i++) t2.push_back(z);
    t2.push_back(vec_t'{"timer_sticky", 1'b0, 7, 32'd1, 1'b0, 5'd0, 5'd0, 32'd0, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"cmp_clr", 1'b0, 7, 32'd0, 1'b1, 5'd11, 5'd0, 32'd100, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"cnt_100", 1'b0, 1, 32'd100, 1'b1, 5'd9, 5'd0, 32'd100, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"clr_beats_match", 1'b0, 7, 32'd0, 1'b1, 5'd11, 5'd0, 32'd200, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"cause_idle", 1'b0, 4, 32'd0, 1'b0, 5'd0, 5'd0, 32'd0, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"status_wr", 1'b0, 3, 32'h10008001, 1'b1, 5'd12, 5'd0, 32'h10008001, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"cause_ip7", 1'b1, 4, 32'h00008000, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"int_req_ip7", 1'b1, 8, 32'd1, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"int_req_masked", 1'b0, 8, 32'd0, 1'b0, 5'd0, 5'd0, 32'd0, 6'h01, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"cause_ip2", 1'b1, 4, 32'h00000400, 1'b0, 5'd0, 5'd0, 32'd0, 6'h01, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"exc_epc_bd", 1'b0, 5, 32'hBFC00100, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b1, 5'd4, 32'hBFC00104, 1'b1, 32'h13, 1'b0});
    t2.push_back(vec_t'{"exc_cause", 1'b1, 4, 32'h80008010, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"exc_badvaddr", 1'b1, 6, 32'h13, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"exc_exl", 1'b1, 3, 32'h10008003, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"exl_blocks_int", 1'b1, 8, 32'd0, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"nested_epc", 1'b0, 5, 32'hBFC00100, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b1, 5'd0, 32'h80000000, 1'b0, 32'hFFFF, 1'b0});
    t2.push_back(vec_t'{"nested_cause", 1'b1, 4, 32'h80008000, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"nested_bva_kept", 1'b1, 6, 32'h13, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"ades_bva", 1'b0, 6, 32'h55, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b1, 5'd5, 32'h0, 1'b0, 32'h55, 1'b0});
    t2.push_back(vec_t'{"ades_cause", 1'b1, 4, 32'h80008014, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"eret", 1'b0, 3, 32'h10008001, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1});
    t2.push_back(vec_t'{"eret_int_req", 1'b1, 8, 32'd1, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"exc_over_eret", 1'b0, 3, 32'h10008003, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b1, 5'd0, 32'h100, 1'b0, 32'd0, 1'b1});
    t2.push_back(vec_t'{"exc_over_eret_epc", 1'b1, 5, 32'h100, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"bd_cleared", 1'b1, 4, 32'h00008000, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"eret2", 1'b0, 3, 32'h10008001, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1});
    t2.push_back(vec_t'{"no_fwd_other_reg", 1'b1, 0, 32'h100, 1'b1, 5'd12, 5'd14, 32'h10008001, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"fwd_cause", 1'b1, 0, 32'h00C08300, 1'b1, 5'd13, 5'd13, 32'hFFFFFFFF, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"cause_after_wr", 1'b1, 4, 32'h00C08300, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"fwd_status", 1'b1, 0, 32'h10000001, 1'b1, 5'd12, 5'd12, 32'h10000001, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"prid_wr_ignored", 1'b1, 0, 32'h004C0102, 1'b1, 5'd15, 5'd15, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"prid_rd", 1'b1, 0, 32'h004C0102, 1'b0, 5'd0, 5'd15, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"config_rd", 1'b1, 0, 32'h00008000, 1'b0, 5'd0, 5'd16, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"bva_wr_ignored", 1'b1, 0, 32'h55, 1'b1, 5'd8, 5'd8, 32'hFFFF, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"bva_rd", 1'b1, 0, 32'h55, 1'b0, 5'd0, 5'd8, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"compare_rd", 1'b1, 0, 32'd200, 1'b0, 5'd0, 5'd11, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"unmapped_rd", 1'b1, 0, 32'd0, 1'b0, 5'd0, 5'd3, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"exc_with_st_wr", 1'b0, 3, 32'h2, 1'b1, 5'd12, 5'd0, 32'd0, 6'h20, 1'b1, 5'd0, 32'h200, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"exc_with_st_wr_epc", 1'b1, 5, 32'h200, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"eret_over_st_wr", 1'b0, 3, 32'h10000001, 1'b1, 5'd12, 5'd0, 32'h10000003, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1});
    t2.push_back(vec_t'{"cnt_max", 1'b0, 1, 32'hFFFFFFFF, 1'b1, 5'd9, 5'd0, 32'hFFFFFFFF, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(z);
    t2.push_back(z);
    t2.push_back(vec_t'{"cnt_hold_presc", 1'b0, 1, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"cnt_wrap", 1'b0, 1, 32'd0, 1'b0, 5'd0, 5'd0, 32'd0, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    t2.push_back(vec_t'{"epc_wr", 1'b0, 5, 32'h12345678, 1'b1, 5'd14, 5'd0, 32'h12345678, 6'h20, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0});
    drive(z);
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(exp_t'{"rst_data_u1", 1'b0, 0, 32'd0});
    sb.push_back(exp_t'{"rst_data_u4", 1'b1, 0, 32'd0});
    sb.push_back(exp_t'{"rst_count", 1'b1, 1, 32'd0});
    sb.push_back(exp_t'{"rst_status", 1'b0, 3, 32'h10000000});
    sb.push_back(exp_t'{"rst_cause", 1'b0, 4, 32'd0});
    sb.push_back(exp_t'{"rst_timer", 1'b1, 7, 32'd0});
    check_all();
    rst = 1'b0;
    z.ra = 5'd0;
    repeat (10) run(z);
    sb.push_back(exp_t'{"count_div1", 1'b0, 1, 32'd10});
    sb.push_back(exp_t'{"count_div4", 1'b1, 1, 32'd2});
    sb.push_back(exp_t'{"idle_status", 1'b0, 3, 32'h10000000});
    check_all();
    z.ra = 5'd15;
    drive(z);
    #1;
    sb.push_back(exp_t'{"prid_u1", 1'b0, 0, 32'h004C0102});
    check_all();
    z.ra = 5'd3;
    drive(z);
    #1;
    sb.push_back(exp_t'{"unmapped_u1", 1'b0, 0, 32'd0});
    check_all();
    foreach (t1[i]) run(t1[i]);
    n = 0;
    while (b.timer_int_o !== 1'b1 && n < 40) begin
      run(z);
      n++;
    end
    chk("timer_latency", 32'(n), 32'd20);
    sb.push_back(exp_t'{"timer_count", 1'b1, 1, 32'd5});
    sb.push_back(exp_t'{"timer_cause15", 1'b1, 4, 32'h00008000});
    check_all();
    foreach (t2[i]) run(t2[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
